// File: rtl/hw_itr_sequencer_pkg.sv
// Shared types and constants for the hardware-interrupt sequencer.
//   hw_itr_state_e     : sequencer FSM states
//   hw_itr_cause_t     : default-width IRQ cause code
//   HW_ITR_HANDLER_PC  : default handler entry address
//   hw_itr_sat_inc8    : saturating 8-bit increment
package hw_itr_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    ENTER,
    HANDLER,
    EXIT
  } hw_itr_state_e;

  typedef logic [3:0] hw_itr_cause_t;

  localparam logic [31:0] HW_ITR_HANDLER_PC = 32'h8000_1000;

  function automatic logic [7:0] hw_itr_sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/hw_itr_cause_fifo.sv
// Pending IRQ cause FIFO.
//   clk, reset_n : clock, asynchronous active-low reset
//   push, wdata  : enqueue request (ignored when full)
//   pop          : dequeue request (ignored when empty)
//   rdata        : head entry
//   full, empty  : flags decoded from the registered occupancy count
// Flags come only from the registered count, so a pop in the same cycle never
// makes room for a push.
module hw_itr_cause_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/hw_itr_sequencer.sv
// Hardware-interrupt sequencer for warp 0.
// Queues IRQ causes, drains warp 0, redirects it to the handler and saves the
// resume PC. The handler's overloaded WSPAWN (WspawnPCplus4 strobe) marks the
// return, after which warp 0 is redirected back to the saved EPC.
//   clk, reset_n                 : clock, asynchronous active-low reset
//   irq_valid/irq_cause/irq_ready: IRQ cause enqueue handshake
//   itr_enable                   : global interrupt enable from CSRs
//   wspawn_pc4, wspawn_pc4_wr    : return-marker PC and strobe from execute
//   warp0_pc, warp0_idle         : warp-0 next PC and no-instruction-in-flight
//   stall_warp0                  : block warp-0 issue
//   redirect_valid/pc/ready      : PC redirect handshake to the scheduler
//   in_handler, cur_cause, epc   : service status
//   marker_pc                    : last accepted return-marker PC
//   spurious_cnt                 : saturating count of strobes outside HANDLER
module hw_itr_sequencer
  import hw_itr_sequencer_pkg::*;
#(
  parameter int unsigned PC_BITS    = 32,
  parameter int unsigned CAUSE_BITS = 4,
  parameter int unsigned PEND_DEPTH = 4,
  parameter logic [PC_BITS-1:0] HANDLER_PC = PC_BITS'(HW_ITR_HANDLER_PC)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  irq_valid,
  input  logic [CAUSE_BITS-1:0] irq_cause,
  output logic                  irq_ready,
  input  logic                  itr_enable,
  input  logic [PC_BITS-1:0]    wspawn_pc4,
  input  logic                  wspawn_pc4_wr,
  input  logic [PC_BITS-1:0]    warp0_pc,
  input  logic                  warp0_idle,
  output logic                  stall_warp0,
  output logic                  redirect_valid,
  output logic [PC_BITS-1:0]    redirect_pc,
  input  logic                  redirect_ready,
  output logic                  in_handler,
  output logic [CAUSE_BITS-1:0] cur_cause,
  output logic [PC_BITS-1:0]    epc,
  output logic [PC_BITS-1:0]    marker_pc,
  output logic [7:0]            spurious_cnt
);

  hw_itr_state_e         state_q, state_d;
  logic [PC_BITS-1:0]    epc_q;
  logic [PC_BITS-1:0]    marker_q;
  logic [CAUSE_BITS-1:0] cause_q;
  logic [7:0]            spur_q;

  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CAUSE_BITS-1:0] fifo_head;

  // Only DRAIN pops, and DRAIN is only entered with a non-empty FIFO.
  assign fifo_pop = (state_q == DRAIN) & itr_enable & warp0_idle;

  hw_itr_cause_fifo #(
    .DEPTH (PEND_DEPTH),
    .WIDTH (CAUSE_BITS)
  ) u_cause_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (irq_valid),
    .wdata   (irq_cause),
    .pop     (fifo_pop),
    .rdata   (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign irq_ready    = ~fifo_full;
  assign cur_cause    = cause_q;
  assign epc          = epc_q;
  assign marker_pc    = marker_q;
  assign spurious_cnt = spur_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!fifo_empty && itr_enable) state_d = DRAIN;
      DRAIN: begin
        if (!itr_enable)     state_d = IDLE;
        else if (warp0_idle) state_d = ENTER;
      end
      ENTER:   if (redirect_ready) state_d = HANDLER;
      HANDLER: if (wspawn_pc4_wr)  state_d = EXIT;
      EXIT:    if (redirect_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode only registered state and registered EPC, so the redirect
  // request is glitch-free and stable while waiting for ready.
  always_comb begin
    stall_warp0    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    in_handler     = 1'b0;
    unique case (state_q)
      DRAIN: stall_warp0 = 1'b1;
      ENTER: begin
        stall_warp0    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = HANDLER_PC;
      end
      HANDLER: in_handler = 1'b1;
      EXIT: begin
        stall_warp0    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = epc_q;
        in_handler     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      epc_q    <= '0;
      cause_q  <= '0;
      marker_q <= '0;
      spur_q   <= '0;
    end else begin
      if (fifo_pop) begin
        epc_q   <= warp0_pc;
        cause_q <= fifo_head;
      end
      if (wspawn_pc4_wr) begin
        if (state_q == HANDLER) marker_q <= wspawn_pc4;
        else                    spur_q   <= hw_itr_sat_inc8(spur_q);
      end
    end
  end

endmodule
